// File: rtl/remult_seq.sv
// remult_seq: sequential shift-add multiply-accumulate, y = q*d + r.
// Inverse of the 16-bit sequential divider: a quotient/remainder pair goes
// in and the original dividend comes back out. One adder, one multiplier bit
// per clock, fixed latency of WIDTH iterations with no early exit.
module remult_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_q,
    input  logic [WIDTH-1:0]     i_d,
    input  logic [WIDTH-1:0]     i_r,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_y
);

    // Iteration counter only needs to reach WIDTH-1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;

    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mult;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_y;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_lastIter;
    logic [2*WIDTH-1:0]   w_accNext;

    // A start is only honoured from IDLE; RUN and DONE both ignore it.
    assign w_accept   = (r_state == IDLE) && i_start;
    assign w_lastIter = (r_state == RUN) && (r_cnt == LAST_CNT);

    // The single adder: conditionally add the shifted multiplicand. The sum
    // never carries out because (2^W-1)^2 + (2^W-1) still fits in 2W bits.
    assign w_accNext = r_mult[0] ? (r_acc + r_mcand) : r_acc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last
    // iteration, DONE always returns to IDLE one cycle later.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (w_lastIter) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath: operands are captured on the accepting edge only, so later
    // input changes cannot disturb an operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_mult  <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_acc   <= {{WIDTH{1'b0}}, i_r};
            r_mcand <= {{WIDTH{1'b0}}, i_d};
            r_mult  <= i_q;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_acc   <= w_accNext;
            r_mcand <= r_mcand << 1;
            r_mult  <= r_mult >> 1;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Result and completion strobe: y captures the final sum (including the
    // last iteration's add) on the DONE-entry edge and holds until the next
    // completion; done is a registered one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_lastIter;
            if (w_lastIter) begin
                r_y <= w_accNext;
            end
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;
    assign o_y    = r_y;

endmodule

// File: tb/tb_remult_seq.sv
// tb_remult_seq: scoreboard bench for remult_seq. The driver pushes
// q*d + r onto a queue for every start it issues; a monitor pops and
// compares whenever done is seen.
module tb_remult_seq;

    localparam int W = 16;

    logic            clk;
    logic            rst;
    logic            iStart;
    logic [W-1:0]    iQ;
    logic [W-1:0]    iD;
    logic [W-1:0]    iR;
    logic            oBusy;
    logic            oDone;
    logic [2*W-1:0]  oY;

    logic [2*W-1:0]  expQ[$];
    int              checks = 0;
    int              errors = 0;
    int              doneCount = 0;
    int              startsIssued = 0;
    logic            prevDone = 1'b0;

    remult_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (iStart),
        .i_q     (iQ),
        .i_d     (iD),
        .i_r     (iR),
        .o_busy  (oBusy),
        .o_done  (oDone),
        .o_y     (oY)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on wide integers.
    function automatic logic [2*W-1:0] refModel(input logic [W-1:0] q,
                                                input logic [W-1:0] d,
                                                input logic [W-1:0] r);
        longint unsigned prod;
        prod = longint'(q) * longint'(d) + longint'(r);
        return prod[2*W-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                               input logic [2*W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Waits (bounded) for an idle DUT, then issues a one-cycle start pulse
    // and records the expected result. Returns on the negedge after the
    // accepting edge.
    task automatic applyStimulus(input logic [W-1:0] q, input logic [W-1:0] d,
                                 input logic [W-1:0] r);
        int n;
        n = 0;
        @(negedge clk);
        while (oBusy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (oBusy) begin
            checkOutput("idleTimeout", 32'(oBusy), 32'd0);
        end
        iQ     = q;
        iD     = d;
        iR     = r;
        iStart = 1'b1;
        expQ.push_back(refModel(q, d, r));
        startsIssued++;
        @(negedge clk);
        iStart = 1'b0;
    endtask

    // Bounded wait until the monitor has seen `target` done pulses.
    task automatic waitDone(input int target);
        int n;
        n = 0;
        while (doneCount < target && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (doneCount < target) begin
            checkOutput("doneTimeout", 32'(doneCount), 32'(target));
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding
    // expectation, and done must never last more than one cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (oDone) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedDone: y=0x%0h with no start outstanding", oY);
                end else begin
                    checkOutput("y", oY, expQ.pop_front());
                end
                if (prevDone) begin
                    checkOutput("donePulseWidth", 32'd2, 32'd1);
                end
            end
            prevDone = oDone;
        end else begin
            prevDone = 1'b0;
        end
    end

    initial begin
        int busyCycles;
        int doneAt;
        int holdBad;
        int baseDone;
        logic [W-1:0] rq;
        logic [W-1:0] rd;
        logic [W-1:0] rr;

        rst    = 1'b1;
        iStart = 1'b0;
        iQ     = '0;
        iD     = '0;
        iR     = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("resetBusy", 32'(oBusy), 32'd0);
        checkOutput("resetDone", 32'(oDone), 32'd0);
        checkOutput("resetY", oY, 32'd0);
        rst = 1'b0;

        // 33*3+1 = 100; done 16 cycles after the start edge, busy for 17.
        applyStimulus(16'd33, 16'd3, 16'd1);
        busyCycles = 0;
        doneAt     = -1;
        while (oBusy && busyCycles < 40) begin
            if (oDone && doneAt < 0) begin
                doneAt = busyCycles;
            end
            busyCycles++;
            @(negedge clk);
        end
        checkOutput("busyCycles", 32'(busyCycles), 32'd17);
        checkOutput("doneLatency", 32'(doneAt), 32'd16);
        checkOutput("yAfterFirst", oY, 32'd100);

        // Back-to-back: second start issued as soon as busy drops; y must
        // keep the first result until the second done.
        baseDone = doneCount;
        applyStimulus(16'd51, 16'd5, 16'd0);
        waitDone(baseDone + 1);
        applyStimulus(16'd22, 16'd56, 16'd2);
        holdBad = 0;
        busyCycles = 0;
        while (!oDone && busyCycles < 40) begin
            if (oY !== 32'd255) begin
                holdBad++;
            end
            busyCycles++;
            @(negedge clk);
        end
        checkOutput("yHold255", 32'(holdBad), 32'd0);
        checkOutput("yBackToBack", oY, 32'd1234);

        // Overflow boundary and zero operands.
        applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF);
        applyStimulus(16'd0, 16'd0, 16'd7);
        waitDone(startsIssued);
        checkOutput("yZeroOps", oY, 32'd7);

        // Starts during RUN and during DONE are ignored.
        baseDone = doneCount;
        applyStimulus(16'd10, 16'd10, 16'd0);
        repeat (3) @(negedge clk);
        iQ = 16'd2;
        iD = 16'd2;
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        busyCycles = 0;
        while (!oDone && busyCycles < 40) begin
            busyCycles++;
            @(negedge clk);
        end
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("ignoredStartBusy", 32'(oBusy), 32'd0);
        checkOutput("ignoredStartDones", 32'(doneCount - baseDone), 32'd1);
        checkOutput("ignoredStartY", oY, 32'd100);

        // Asynchronous reset in the middle of RUN.
        applyStimulus(16'd123, 16'd45, 16'd6);
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midResetBusy", 32'(oBusy), 32'd0);
        checkOutput("midResetDone", 32'(oDone), 32'd0);
        checkOutput("midResetY", oY, 32'd0);
        expQ.delete();
        startsIssued = doneCount;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(16'd7, 16'd9, 16'd4);
        waitDone(startsIssued);
        @(negedge clk);
        checkOutput("yAfterReset", oY, 32'd67);

        // Randomised quotient/divisor/remainder triples with r < d.
        for (int i = 0; i < 200; i++) begin
            rq = 16'($urandom);
            rd = 16'($urandom_range(1, 65535));
            rr = 16'($urandom_range(0, int'(rd) - 1));
            applyStimulus(rq, rd, rr);
        end
        waitDone(startsIssued);
        repeat (2) @(negedge clk);
        checkOutput("startDoneBalance", 32'(doneCount), 32'(startsIssued));
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
